// File: rtl/guess_pkg.sv
// Shared guessing-game definitions: button count, button indices and the button vector type.
package guess_pkg;

    localparam int NUM_BUTTONS = 4;

    localparam int BTN0 = 0;
    localparam int BTN1 = 1;
    localparam int BTN2 = 2;
    localparam int BTN3 = 3;

    typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

    function automatic logic at_least_two(input btn_vec_t v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            n += int'(v[i]);
        end
        return (n >= 2);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-flop synchroniser, stability counter, debounced level and edge pulses.
// Release pulses exist only when BUTTON_CONDITIONER_RELEASE_EN is defined.
module debounce_bit #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic level_next_o,
    output logic press_next_o
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
`ifdef BUTTON_CONDITIONER_RELEASE_EN
    logic          rel_q, rel_d;
`endif

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
`ifdef BUTTON_CONDITIONER_RELEASE_EN
        rel_d   = 1'b0;
`endif
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = s2_q;
            press_d = s2_q;
`ifdef BUTTON_CONDITIONER_RELEASE_EN
            rel_d   = ~s2_q;
`endif
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef BUTTON_CONDITIONER_RELEASE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= rel_d;
        end
    end
    assign release_o = rel_q;
`else
    assign release_o = 1'b0;
`endif

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign level_next_o = level_d;
    assign press_next_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw game buttons into debounced levels and single-cycle press/release pulses.
// Release pulses are generated only when BUTTON_CONDITIONER_RELEASE_EN is defined.
module button_conditioner
    import guess_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic     clk,
    input  logic     reset,
    input  btn_vec_t btn_raw,
    output btn_vec_t btn_level,
    output btn_vec_t btn_press,
    output btn_vec_t btn_release,
    output logic     any_press,
    output logic     multi_held
);

    btn_vec_t level_d;
    btn_vec_t press_d;
    logic     any_press_q;
    logic     multi_held_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .raw_i        (btn_raw[i]),
            .level_o      (btn_level[i]),
            .press_o      (btn_press[i]),
            .release_o    (btn_release[i]),
            .level_next_o (level_d[i]),
            .press_next_o (press_d[i])
        );
    end

    // Built from next-state values so the summaries land in the same cycle as the per-button flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_press_q  <= 1'b0;
            multi_held_q <= 1'b0;
        end else begin
            any_press_q  <= |press_d;
            multi_held_q <= at_least_two(level_d);
        end
    end

    assign any_press  = any_press_q;
    assign multi_held = multi_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DB_CYCLES = 4): directed cases plus randomized bouncing.
module tb_button_conditioner;
    import guess_pkg::*;

    localparam int DB = 4;
    localparam logic [63:0] MASK = (64'd1 << DB) - 64'd1;
`ifdef BUTTON_CONDITIONER_RELEASE_EN
    localparam btn_vec_t REL_1010 = 4'b1010;
`else
    localparam btn_vec_t REL_1010 = 4'b0000;
`endif

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    btn_vec_t btn_raw = '0;
    btn_vec_t btn_level, btn_press, btn_release;
    logic     any_press, multi_held;

    int checks = 0;
    int errors = 0;

    button_conditioner #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press),
        .multi_held  (multi_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input btn_vec_t act, input btn_vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: raw input reaches the debouncer two edges late; the level flips once
    // the last DB synchronised samples taken since the previous flip all disagree with it.
    btn_vec_t    pipe0 = '0, pipe1 = '0;
    btn_vec_t    m_level = '0, m_press = '0, m_rel = '0;
    logic        m_any = 1'b0, m_multi = 1'b0;
    logic [63:0] hist [NUM_BUTTONS];
    int          since [NUM_BUTTONS];

    always @(posedge clk) begin
        if (!reset) begin
            pipe0 = '0; pipe1 = '0;
            m_level = '0; m_press = '0; m_rel = '0;
            m_any = 1'b0; m_multi = 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hist[i]  = '0;
                since[i] = 0;
            end
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hist[i]  = {hist[i][62:0], pipe1[i]};
                since[i] = since[i] + 1;
                if (since[i] >= DB && (hist[i] & MASK) == (m_level[i] ? 64'd0 : MASK)) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) m_press[i] = 1'b1;
                    else            m_rel[i]   = 1'b1;
                    since[i] = 0;
                end
            end
            pipe1 = pipe0;
            pipe0 = btn_raw;
            m_any   = |m_press;
            m_multi = ($countones(m_level) >= 2);
`ifndef BUTTON_CONDITIONER_RELEASE_EN
            m_rel = '0;
`endif
        end
    end

    always @(negedge clk) begin
        check("model_level",   btn_level,               m_level);
        check("model_press",   btn_press,               m_press);
        check("model_release", btn_release,             m_rel);
        check("model_any",     btn_vec_t'(any_press),   btn_vec_t'(m_any));
        check("model_multi",   btn_vec_t'(multi_held),  btn_vec_t'(m_multi));
    end

    initial begin
        // Reset held low for three cycles, then released with no buttons.
        repeat (3) begin
            step(1);
            check("rst_level", btn_level, 4'b0000);
            check("rst_press", btn_press, 4'b0000);
        end
        #1 reset = 1'b1;
        step(3);
        check("post_rst_level", btn_level, 4'b0000);
        check("post_rst_any", btn_vec_t'(any_press), 4'b0000);

        // Single press on button 0: level and pulse after exactly six edges.
        #1 btn_raw = 4'b0001;
        step(5);
        check("b0_level_early", btn_level, 4'b0000);
        check("b0_press_early", btn_press, 4'b0000);
        step(1);
        check("b0_level", btn_level, 4'b0001);
        check("b0_press", btn_press, 4'b0001);
        check("b0_any", btn_vec_t'(any_press), 4'b0001);
        step(1);
        check("b0_press_width", btn_press, 4'b0000);
        check("b0_any_width", btn_vec_t'(any_press), 4'b0000);
        step(13);
        #1 btn_raw = 4'b0000;
        step(10);
        check("b0_released", btn_level, 4'b0000);

        // Button 2 bounces every cycle: nothing may come through.
        for (int c = 0; c < 12; c++) begin
            #1 btn_raw[BTN2] = (c % 2 == 0);
            step(1);
            check("bounce_press", btn_press, 4'b0000);
        end
        #1 btn_raw = 4'b0000;
        step(8);
        check("bounce_level", btn_level, 4'b0000);

        // Two buttons together.
        #1 btn_raw = 4'b1010;
        step(5);
        check("dual_press_early", btn_press, 4'b0000);
        step(1);
        check("dual_press", btn_press, 4'b1010);
        check("dual_multi", btn_vec_t'(multi_held), 4'b0001);
        check("dual_any", btn_vec_t'(any_press), 4'b0001);
        step(4);
        check("dual_multi_held", btn_vec_t'(multi_held), 4'b0001);
        #1 btn_raw = 4'b0000;
        step(5);
        check("dual_multi_before_rel", btn_vec_t'(multi_held), 4'b0001);
        step(1);
        check("dual_multi_off", btn_vec_t'(multi_held), 4'b0000);
        check("dual_release", btn_release, REL_1010);
        check("dual_level_off", btn_level, 4'b0000);
        step(4);

        // Button 1: three-cycle blip is ignored, a long hold is one press.
        #1 btn_raw = 4'b0010;
        step(3);
        #1 btn_raw = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step(1);
            check("short_press", btn_press, 4'b0000);
        end
        #1 btn_raw = 4'b0010;
        step(5);
        check("long_press_early", btn_press, 4'b0000);
        step(1);
        check("long_press", btn_press, 4'b0010);
        #1 btn_raw = 4'b0000;
        step(10);

        // Reset while button 3 is mid-count; held button becomes a fresh press.
        #1 btn_raw = 4'b1000;
        step(4);
        #1 reset = 1'b0;
        #1;
        check("midrst_level", btn_level, 4'b0000);
        check("midrst_press", btn_press, 4'b0000);
        check("midrst_any", btn_vec_t'(any_press), 4'b0000);
        step(2);
        #1 reset = 1'b1;
        step(5);
        check("midrst_press_early", btn_press, 4'b0000);
        step(1);
        check("midrst_press_b3", btn_press, 4'b1000);
        check("midrst_level_b3", btn_level, 4'b1000);
        #1 btn_raw = 4'b0000;
        step(10);

        // Randomized bouncing on all buttons with occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            step(1);
            #1;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                step(2);
                #1 reset = 1'b1;
            end
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
            end
        end
        #1 btn_raw = 4'b0000;
        step(10);
        check("final_level", btn_level, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw push-button inputs of the guessing game before they reach the guess state machine. Each button is synchronised, debounced with a per-button stability counter and converted to a single-cycle press pulse, so the FSM sees exactly one event per physical press. Sits directly upstream of the guess FSM: its press pulses drive the FSM's b0..b3 inputs.

## Interface
- DB_CYCLES, default 500000: consecutive cycles a synchronised input must differ from the debounced level before the level changes; legal range 2..2^24.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- btn_raw  in  4  raw, asynchronous button levels, bit i = button i, 1 = pressed.
- btn_level  out  4  debounced button levels.
- btn_press  out  4  one-cycle pulse per debounced 0->1 transition.
- btn_release  out  4  one-cycle pulse per debounced 1->0 transition (see Configuration).
- any_press  out  1  OR of btn_press.
- multi_held  out  1  high while two or more btn_level bits are 1.

## Operation
- Per button i, three stages: 2-flop synchroniser (s1, s2), debounce counter cnt[i], stable register btn_level[i].
- Counter width: $clog2(DB_CYCLES); counts 0..DB_CYCLES-1, never wraps.
- Each edge: if s2[i] == btn_level[i], cnt[i] <= 0. Else if cnt[i] == DB_CYCLES-1, btn_level[i] <= s2[i] and cnt[i] <= 0. Else cnt[i] <= cnt[i]+1.
- Bounce rule: any cycle where s2 returns to btn_level clears the counter; a glitch shorter than DB_CYCLES cycles produces no level change and no pulse.
- btn_press[i] is registered, high in exactly the cycle after the edge where btn_level[i] goes 0->1; same for btn_release[i] on 1->0.
- Buttons are independent; simultaneous transitions on several buttons produce simultaneous pulses in the same cycle. No priority or masking here; the FSM owns arbitration.
- any_press and multi_held are registered from the same-cycle next values, so they align with btn_press / btn_level.
- Reset (async assert, sync-safe deassert by the system reset tree): s1, s2, cnt, btn_level, btn_press, btn_release, any_press, multi_held all 0. A button held through reset deassertion is treated as a fresh press after DB_CYCLES+2 edges.
- Reset mid-count discards partial counts; no pulse is emitted on reset assertion or release.

## Timing
- Press latency: raw change before edge k -> btn_level and btn_press high after edge k+DB_CYCLES+1 (DB_CYCLES+2 edges total); pulse width exactly 1 cycle.
- Release latency identical.
- Minimum distinguishable press: DB_CYCLES consecutive stable synchronised cycles.
- All outputs registered; no combinational path from btn_raw to any output.

## Configuration
- BUTTON_CONDITIONER_RELEASE_EN: when defined, btn_release pulses as specified. When undefined, release-edge logic is removed and btn_release is tied to 4'b0000; all other behaviour unchanged.

## Structure
- Shared package guess_pkg: NUM_BUTTONS = 4, button index constants (BTN0..BTN3), typedef btn_vec_t (logic [NUM_BUTTONS-1:0]).
- Sub-module debounce_bit (synchroniser, counter, level register, press/release edge for one button), instantiated NUM_BUTTONS times by a generate loop; top adds any_press and multi_held.

## Test plan
- DB_CYCLES=4; reset low 3 cycles then high -> all outputs 0 throughout and after.
- btn_raw=4'b0001 held 20 cycles -> btn_level[0]=1 and btn_press=4'b0001 for exactly one cycle, 6 edges after the change; any_press pulses with it.
- btn_raw[2] toggles 1,0,1,0 each cycle for 12 cycles then 0 -> btn_level, btn_press stay 0.
- btn_raw 4'b1010 applied in one cycle and held -> btn_press=4'b1010 in one cycle, multi_held=1 while held; release -> multi_held=0 one debounce later, btn_release=4'b1010 with macro, 4'b0000 without.
- btn_raw[1] held 3 cycles (below DB_CYCLES) -> no pulse; held again 4+ cycles -> one pulse.
- Reset asserted while cnt[3]=2 with btn_raw[3]=1 -> outputs 0 immediately; after deassert, btn_press[3] pulses 6 edges later.
